// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared FSM/owner encodings and line constants for the memory arbiter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int BURST_LEN_DEF = 8;

  // Byte-offset-within-line mask for the default line size (2 bytes per word).
  localparam logic [15:0] LINE_OFS_MASK = 16'(2 * BURST_LEN_DEF - 1);

  // Byte-offset mask for an arbitrary burst length.
  function automatic int line_mask(input int burst_len);
    return 2 * burst_len - 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - 2-way I/D request picker, fixed D>I or round-robin when ARB_RR_EN is defined
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic grant_i,
  output logic grant_d
);

`ifdef ARB_RR_EN
  // On a tie, grant whichever side was not served last; a lone requester always wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      grant_d = (last_owner == OWN_I);
      grant_i = (last_owner == OWN_D);
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end
`else
  // Fixed priority: D always beats I; history is not consulted.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req) begin
      grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pipelined memory port between I-fill and D-fill/store (ARB_RR_EN: round-robin)
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_rvalid,
  output logic [$clog2(BURST_LEN)-1:0] i_rword,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_rvalid,
  output logic [$clog2(BURST_LEN)-1:0] d_rword,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_done,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_rvalid,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int WORD_W = $clog2(BURST_LEN);
  localparam int CNT_W  = WORD_W + 1;
  localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'(line_mask(BURST_LEN));
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(BURST_LEN);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   issue_q, issue_d;
  logic [CNT_W-1:0]   ret_q, ret_d;

  logic grant_i, grant_d;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Next-state, command issue and return routing; everything idles at zero.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_rvalid     = 1'b0;
    i_rword      = '0;
    i_rdata      = '0;
    i_done       = 1'b0;
    d_rvalid     = 1'b0;
    d_rword      = '0;
    d_rdata      = '0;
    d_done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Returns arriving here belong to nobody and are dropped.
        issue_d = '0;
        ret_d   = '0;
        if (grant_d) begin
          owner_d      = OWN_D;
          last_owner_d = OWN_D;
          addr_d       = d_addr;
          state_d      = d_we ? ST_WRITE : ST_BURST;
        end else if (grant_i) begin
          owner_d      = OWN_I;
          last_owner_d = OWN_I;
          addr_d       = i_addr;
          state_d      = ST_BURST;
        end
      end

      ST_BURST: begin
        // Issue one word per cycle from the line base until the whole line is requested.
        if (issue_q < CNT_LIMIT) begin
          mem_en   = 1'b1;
          mem_addr = (addr_q & ~OFS_MASK) + ADDR_W'({issue_q, 1'b0});
          issue_d  = issue_q + 1'b1;
        end
        // Returns come back in order, so the return count is the word index.
        if (mem_rvalid) begin
          ret_d = ret_q + 1'b1;
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rword  = ret_q[WORD_W-1:0];
            d_rdata  = mem_rdata;
            d_done   = (ret_q == CNT_LAST);
          end else begin
            i_rvalid = 1'b1;
            i_rword  = ret_q[WORD_W-1:0];
            i_rdata  = mem_rdata;
            i_done   = (ret_q == CNT_LAST);
          end
          if (ret_q == CNT_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q & ~ADDR_W'(1);
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any transaction in progress without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      addr_q       <= '0;
      issue_q      <= '0;
      ret_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      issue_q      <= issue_d;
      ret_q        <= ret_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-3 pipelined memory (ARB_RR_EN aware)
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_rvalid;
  logic [2:0]  i_rword;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_rvalid;
  logic [2:0]  d_rword;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        stray_v = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rvalid   (i_rvalid),
    .i_rword    (i_rword),
    .i_rdata    (i_rdata),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rvalid   (d_rvalid),
    .d_rword    (d_rword),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed function of the word address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1357;
  endfunction

  // Pipelined memory, read latency 3, sharing rst_n.
  logic [2:0]  pv;
  logic [15:0] pd0, pd1, pd2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv  <= '0;
      pd0 <= '0;
      pd1 <= '0;
      pd2 <= '0;
    end else begin
      pv  <= {pv[1:0], mem_en & ~mem_we};
      pd0 <= memf(mem_addr);
      pd1 <= pd0;
      pd2 <= pd1;
    end
  end
  assign mem_rvalid = pv[2] | stray_v;
  assign mem_rdata  = stray_v ? 16'hDEAD : pd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          gap;
  } cmd_t;

  typedef struct {
    bit          wr;
    logic [2:0]  word;
    logic [15:0] data;
    bit          last;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_i[$];
  rsp_t exp_d[$];

  int n_checks = 0;
  int n_errors = 0;
  int ret_cnt[2];
  int done_cnt[2];
  int last_done_cyc = -100;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_fill(input bit is_d, input logic [15:0] addr, input bit gap);
    cmd_t c;
    rsp_t r;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int n = 0; n < 8; n++) begin
      c.we    = 1'b0;
      c.addr  = base + 16'(2 * n);
      c.wdata = '0;
      c.gap   = gap && (n == 0);
      exp_cmd.push_back(c);
      r.wr   = 1'b0;
      r.word = 3'(n);
      r.data = memf(base + 16'(2 * n));
      r.last = (n == 7);
      if (is_d) exp_d.push_back(r);
      else      exp_i.push_back(r);
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data, input bit gap);
    cmd_t c;
    rsp_t r;
    c.we    = 1'b1;
    c.addr  = addr & 16'hFFFE;
    c.wdata = data;
    c.gap   = gap;
    exp_cmd.push_back(c);
    r.wr   = 1'b1;
    r.word = '0;
    r.data = '0;
    r.last = 1'b1;
    exp_d.push_back(r);
  endtask

  task automatic mon_side(input bit is_d, input logic rv, input logic [2:0] word,
                          input logic [15:0] data, input logic done);
    rsp_t r;
    bit   have;
    string s;
    s = is_d ? "d" : "i";
    if (!rv && !done) begin
      check({s, "_quiet"}, {13'd0, word, data}, 32'd0);
    end else begin
      have = is_d ? (exp_d.size() != 0) : (exp_i.size() != 0);
      check({s, "_pending"}, 32'(have), 32'd1);
      if (have) begin
        if (is_d) r = exp_d.pop_front();
        else      r = exp_i.pop_front();
        check({s, "_rvalid"}, 32'(rv), 32'(!r.wr));
        if (!r.wr) begin
          check({s, "_rword"}, 32'(word), 32'(r.word));
          check({s, "_rdata"}, 32'(data), 32'(r.data));
        end
        check({s, "_done"}, 32'(done), 32'(r.last));
      end
      if (rv) ret_cnt[is_d]++;
      if (done) begin
        done_cnt[is_d]++;
        last_done_cyc = cyc;
      end
    end
  endtask

  // Monitor: compare every memory command and every routed return against the scoreboard.
  always @(negedge clk) begin
    cmd_t c;
    if (rst_n) begin
      if (mem_en) begin
        check("cmd_pending", 32'(exp_cmd.size() != 0), 32'd1);
        if (exp_cmd.size() != 0) begin
          c = exp_cmd.pop_front();
          check("cmd_we", 32'(mem_we), 32'(c.we));
          check("cmd_addr", 32'(mem_addr), 32'(c.addr));
          if (c.we) check("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
          if (c.gap) check("cmd_gap", 32'(cyc - last_done_cyc), 32'd2);
        end
      end
      mon_side(1'b0, i_rvalid, i_rword, i_rdata, i_done);
      mon_side(1'b1, d_rvalid, d_rword, d_rdata, d_done);
    end
  end

  task automatic wait_done(input bit is_d, input int start);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt[is_d] > start) break;
    end
    check(is_d ? "d_done_seen" : "i_done_seen", 32'(done_cnt[is_d] - start), 32'd1);
  endtask

  task automatic do_single(input bit is_d, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata);
    int start;
    start = done_cnt[is_d];
    if (we) push_write(addr, wdata, 1'b0);
    else    push_fill(is_d, addr, 1'b0);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
    end else begin
      i_req  = 1'b1;
      i_addr = addr;
    end
    wait_done(is_d, start);
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_tie(input bit d_first, input logic [15:0] daddr, input logic [15:0] ddata,
                        input logic [15:0] iaddr);
    int si, sd;
    si = done_cnt[0];
    sd = done_cnt[1];
    if (d_first) begin
      push_write(daddr, ddata, 1'b0);
      push_fill(1'b0, iaddr, 1'b1);
    end else begin
      push_fill(1'b0, iaddr, 1'b0);
      push_write(daddr, ddata, 1'b1);
    end
    @(posedge clk);
    #1;
    i_req   = 1'b1;
    i_addr  = iaddr;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = daddr;
    d_wdata = ddata;
    if (d_first) begin
      wait_done(1'b1, sd);
      d_req = 1'b0;
      d_we  = 1'b0;
      wait_done(1'b0, si);
      i_req = 1'b0;
    end else begin
      wait_done(1'b0, si);
      i_req = 1'b0;
      wait_done(1'b1, sd);
      d_req = 1'b0;
      d_we  = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    ret_cnt[0]  = 0;
    ret_cnt[1]  = 0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;

    #1;
    check("reset_outputs", 32'(|{i_rvalid, i_rword, i_rdata, i_done, d_rvalid, d_rword, d_rdata,
                                 d_done, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ties from reset: D first in both modes, and again after D-then-I.
    do_tie(1'b1, 16'h2003, 16'h1234, 16'h0100);
    do_tie(1'b1, 16'h2010, 16'h5678, 16'h0120);

    // Lone D store.
    do_single(1'b1, 1'b1, 16'h1001, 16'hBEEF);

    // Tie after D was served last.
`ifdef ARB_RR_EN
    do_tie(1'b0, 16'h3005, 16'hA5A5, 16'h0200);
`else
    do_tie(1'b1, 16'h3005, 16'hA5A5, 16'h0200);
`endif

    // Lone I fill and wrapping D fill.
    do_single(1'b0, 1'b0, 16'h0236, 16'h0000);
    do_single(1'b1, 1'b0, 16'hFFF4, 16'h0000);

    // Stray return while idle.
    @(posedge clk);
    #1;
    stray_v = 1'b1;
    @(negedge clk);
    check("stray_routed", 32'(|{i_rvalid, d_rvalid, i_done, d_done}), 32'd0);
    @(posedge clk);
    #1;
    stray_v = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after three returns of an I fill.
    push_fill(1'b0, 16'h0500, 1'b0);
    start = ret_cnt[0];
    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 16'h0500;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (ret_cnt[0] >= start + 3) break;
    end
    check("rst_wait_returns", 32'(ret_cnt[0] - start), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midburst_reset_outputs", 32'(|{i_rvalid, i_rword, i_rdata, i_done, d_rvalid, d_rword,
                                          d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    exp_cmd.delete();
    exp_i.delete();
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_single(1'b0, 1'b0, 16'h0040, 16'h0000);
    repeat (6) @(posedge clk);

    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("i_queue_empty", 32'(exp_i.size()), 32'd0);
    check("d_queue_empty", 32'(exp_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
